serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx_pkg.sv | 13 +
 rtl/serial_pattern_tx_run_monitor.sv | 53 +++++
 rtl/serial_pattern_tx.sv | 101 ++++++++++
 tb/tb_serial_pattern_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding and the run-detector length.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int RUN_LEN = 4;

endpackage

// File: rtl/serial_pattern_tx_run_monitor.sv
// Run detector: keeps the last RUN_LEN frame bits and flags equal runs.
// Ports: clock, reset (async low), clear, valid, bit_i -> run_flag (registered).
module run_monitor
  import serial_pattern_tx_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic bit_i,
  output logic run_flag
);

  localparam int FW = $clog2(RUN_LEN + 1);

  logic [RUN_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               run_q, run_d;

  // clear and the first bit of a frame arrive on the same edge,
  // so the clear is applied before the new bit is pushed.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    run_d  = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end
    if (valid) begin
      hist_d = {hist_d[RUN_LEN-2:0], bit_i};
      if (fill_d != FW'(RUN_LEN))
        fill_d = fill_d + 1'b1;
      run_d = (fill_d == FW'(RUN_LEN)) &&
              ((&hist_d) || ~(|hist_d));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      run_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      run_q  <= run_d;
    end
  end

  assign run_flag = run_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// LSB-first serial frame transmitter with busy/done; optional RUN_DETECT_EN.
// Ports: clock, reset (async low), load, data -> out, busy, done [, run_flag].
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             out,
  output logic             busy,
  output logic             done
`ifdef RUN_DETECT_EN
  ,
  output logic             run_flag
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The DONE cycle is also a load sample point, so back-to-back
  // frames repeat every WIDTH+1 cycles.
  always_comb begin
    state_d = IDLE;
    sh_d    = sh_q;
    cnt_d   = '0;
    out_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (load) begin
          state_d = SHIFT;
          sh_d    = data;
          out_d   = data[0];
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
          sh_d    = sh_q >> 1;
          out_d   = sh_q[1];
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef RUN_DETECT_EN
  // busy rising marks a frame start; busy_d marks a bit driven.
  run_monitor u_run (
    .clock    (clock),
    .reset    (reset),
    .clear    (busy_d & ~busy_q),
    .valid    (busy_d),
    .bit_i    (out_d),
    .run_flag (run_flag)
  );
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: frame-queue model plus directed vectors.
// Exercises run detection too when RUN_DETECT_EN is defined.
module tb_serial_pattern_tx;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] data  = '0;
  logic         out, busy, done, run_w;

  int checks   = 0;
  int failures = 0;

`ifdef RUN_DETECT_EN
  serial_pattern_tx #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .load(load), .data(data),
    .out(out), .busy(busy), .done(done), .run_flag(run_w)
  );
  localparam bit RUN_ON = 1'b1;
`else
  serial_pattern_tx #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .load(load), .data(data),
    .out(out), .busy(busy), .done(done)
  );
  assign run_w = 1'b0;
  localparam bit RUN_ON = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic o;
    logic b;
    logic d;
    logic r;
  } ent_t;

  ent_t q[$];
  ent_t exp_e = '0;

  // A frame is a list of future cycles; a load is taken only
  // when nothing of the previous frame is still pending.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      exp_e = '0;
    end else begin
      if (load && q.size() == 0) begin
        for (int i = 0; i < W; i++) begin
          ent_t e;
          e.o = data[i];
          e.b = 1'b1;
          e.d = 1'b0;
          e.r = RUN_ON && i >= 3 && data[i] == data[i-1] &&
                data[i-1] == data[i-2] && data[i-2] == data[i-3];
          q.push_back(e);
        end
        q.push_back(4'b0010);
      end
      if (q.size() > 0) exp_e = q.pop_front();
      else exp_e = '0;
    end
  end

  always @(negedge clock) begin
    chk("out",  {31'b0, out},   {31'b0, exp_e.o});
    chk("busy", {31'b0, busy},  {31'b0, exp_e.b});
    chk("done", {31'b0, done},  {31'b0, exp_e.d});
    chk("run",  {31'b0, run_w}, {31'b0, exp_e.r});
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic grab(input int inj, output logic [7:0] v,
                      output logic [7:0] r, output int nb);
    nb = 0;
    for (int i = 0; i < W; i++) begin
      v[i] = out;
      r[i] = run_w;
      nb += busy;
      if (i == inj) begin
        load = 1'b1;
        data = 8'hFF;
      end else begin
        load = 1'b0;
        data = 8'(i * 37);
      end
      step();
    end
  endtask

  task automatic start(input logic [7:0] d);
    load = 1'b1;
    data = d;
    step();
  endtask

  logic [7:0] v, r;
  int nb, nd, ns, last_d;
  logic pb;

  initial begin
    #3;
    chk("rst_out",  {31'b0, out},  0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    step();
    reset = 1'b1;
    step();

    start(8'hA5);
    grab(-1, v, r, nb);
    chk("a5_bits", {24'b0, v}, 32'hA5);
    chk("a5_busy", nb, 8);
    chk("a5_done", {31'b0, done}, 1);
    step();
    chk("a5_done_end", {31'b0, done}, 0);
    step();

    start(8'h3C);
    grab(2, v, r, nb);
    chk("3c_bits", {24'b0, v}, 32'h3C);
    chk("3c_done", {31'b0, done}, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("3c_noframe", {31'b0, busy}, 0);
    end

    start(8'hFF);
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ff_mid", {31'b0, busy}, 1);
    reset = 1'b0;
    #1;
    chk("ff_rst_out",  {31'b0, out},  0);
    chk("ff_rst_busy", {31'b0, busy}, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ff_nodone", {31'b0, done}, 0);
    end
    reset = 1'b1;
    start(8'h01);
    grab(-1, v, r, nb);
    chk("01_bits", {24'b0, v}, 32'h01);
    chk("01_done", {31'b0, done}, 1);
    step();
    step();

    nd = 0;
    ns = 0;
    last_d = 0;
    pb = busy;
    load = 1'b1;
    data = 8'h96;
    for (int s = 1; s <= 36; s++) begin
      step();
      if (done) begin
        nd++;
        last_d = s;
      end
      if (busy && !pb) ns++;
      pb = busy;
    end
    load = 1'b0;
    chk("hold_dones", nd, 4);
    chk("hold_starts", ns, 4);
    chk("hold_last", last_d, 36);
    step();
    step();

`ifdef RUN_DETECT_EN
    start(8'hF0);
    grab(-1, v, r, nb);
    chk("f0_bits", {24'b0, v}, 32'hF0);
    chk("f0_run",  {24'b0, r}, 32'h88);
    step();
    step();

    start(8'h80);
    grab(-1, v, r, nb);
    chk("80_run", {24'b0, r}, 32'h78);
    load = 1'b1;
    data = 8'h00;
    step();
    grab(-1, v, r, nb);
    chk("00_bits", {24'b0, v}, 32'h00);
    chk("00_run",  {24'b0, r}, 32'hF8);
    step();
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
